ysyx_220053_instr_to_imm: RTL and testbench

//  RV64I immediate generator for the ysyx_220053 decode stage (IDU).
//  - Extracts and sign/zero-extends the instruction immediate to 64 bits, selected by the controller's ExtOp.
//  - Provides a combinational result for same-cycle decode and a registered copy for the next pipeline stage.

---
 rtl/ysyx_220053_pkg.sv | 22 ++
 rtl/ysyx_220053_instr_to_imm_if.sv | 29 ++
 rtl/ysyx_220053_imm_reg.sv | 46 ++++
 rtl/ysyx_220053_instr_to_imm.sv | 50 +++++
 tb/tb_ysyx_220053_instr_to_imm.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ysyx_220053_pkg.sv
// Shared decode definitions for the ysyx_220053 core.
// Holds the datapath widths and the ExtOp immediate-format encoding that the
// controller drives and the immediate generator decodes.
package ysyx_220053_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned EXTOP_W = 3;

  typedef logic [EXTOP_W-1:0] ext_op_t;

  // Immediate format select
  localparam ext_op_t EXT_I     = 3'd0;
  localparam ext_op_t EXT_U     = 3'd1;
  localparam ext_op_t EXT_S     = 3'd2;
  localparam ext_op_t EXT_B     = 3'd3;
  localparam ext_op_t EXT_J     = 3'd4;
  localparam ext_op_t EXT_ZIMM  = 3'd5;
  localparam ext_op_t EXT_SHAMT = 3'd6;
  localparam ext_op_t EXT_NONE  = 3'd7;

endpackage

// File: rtl/ysyx_220053_instr_to_imm_if.sv
// Bus between the decode controller and the immediate generator.
//   valid_i  instr_i/ExtOp valid this cycle
//   instr_i  raw 32-bit instruction word
//   ExtOp    immediate format select
//   imm      combinational 64-bit immediate
//   imm_q    immediate captured on the last valid_i edge
//   valid_q  imm_q was captured on the previous edge
// master = decode side driving the instruction, slave = immediate generator.
interface ysyx_220053_instr_to_imm_if;
  import ysyx_220053_pkg::*;

  logic            valid_i;
  logic [ILEN-1:0] instr_i;
  ext_op_t         ExtOp;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] imm_q;
  logic            valid_q;

  modport master (
    output valid_i, instr_i, ExtOp,
    input  imm, imm_q, valid_q
  );

  modport slave (
    input  valid_i, instr_i, ExtOp,
    output imm, imm_q, valid_q
  );

endinterface

// File: rtl/ysyx_220053_imm_reg.sv
// Pipeline register for the decoded immediate.
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset (wins over valid_i)
//   valid_i    capture imm_i this edge
//   imm_i      immediate to capture
//   imm_q_o    captured immediate, held across idle cycles
//   valid_q_o  high for exactly the cycle after a capture
module ysyx_220053_imm_reg
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned Width = XLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] imm_i,
  output logic [Width-1:0] imm_q_o,
  output logic             valid_q_o
);

  logic [Width-1:0] imm_d, imm_q;
  logic             valid_d, valid_q;

  always_comb begin
    imm_d   = imm_q;
    valid_d = 1'b0;
    if (valid_i) begin
      imm_d   = imm_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign imm_q_o   = imm_q;
  assign valid_q_o = valid_q;

endmodule

// File: rtl/ysyx_220053_instr_to_imm.sv
// RV64I immediate generator for the decode stage.
// Extracts the immediate selected by ExtOp and sign/zero-extends it to 64 bits;
// drives it combinationally on imm and a one-cycle registered copy on imm_q.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   slave side of ysyx_220053_instr_to_imm_if
module ysyx_220053_instr_to_imm
  import ysyx_220053_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  ysyx_220053_instr_to_imm_if.slave     bus
);

  logic [ILEN-1:0] in;
  logic [XLEN-1:0] imm_d;
  logic            sgn;

  assign in  = bus.instr_i;
  assign sgn = in[31];  // every signed format extends from the word's MSB

  always_comb begin
    imm_d = '0;
    case (bus.ExtOp)
      EXT_I:     imm_d = {{52{sgn}}, in[31:20]};
      EXT_U:     imm_d = {{32{sgn}}, in[31:12], 12'b0};
      EXT_S:     imm_d = {{52{sgn}}, in[31:25], in[11:7]};
      EXT_B:     imm_d = {{51{sgn}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      EXT_J:     imm_d = {{43{sgn}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      EXT_ZIMM:  imm_d = {59'b0, in[19:15]};
      EXT_SHAMT: imm_d = {58'b0, in[25:20]};
      EXT_NONE:  imm_d = '0;
      default:   imm_d = '0;
    endcase
  end

  assign bus.imm = imm_d;

  ysyx_220053_imm_reg #(
    .Width (XLEN)
  ) u_imm_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (bus.valid_i),
    .imm_i     (imm_d),
    .imm_q_o   (bus.imm_q),
    .valid_q_o (bus.valid_q)
  );

endmodule

// File: tb/tb_ysyx_220053_instr_to_imm.sv
module tb_ysyx_220053_instr_to_imm;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;

  ysyx_220053_instr_to_imm_if bus ();

  ysyx_220053_instr_to_imm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference immediate: the numeric value of each format's field, scaled.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] op);
    longint     v;
    logic [11:0] f12;
    logic [19:0] f20;
    v = 0;
    case (op)
      3'd0: begin f12 = w[31:20]; v = longint'($signed(f12)); end
      3'd1: begin f20 = w[31:12]; v = longint'($signed(f20)) * 4096; end
      3'd2: begin f12 = {w[31:25], w[11:7]}; v = longint'($signed(f12)); end
      3'd3: begin f12 = {w[31], w[7], w[30:25], w[11:8]}; v = longint'($signed(f12)) * 2; end
      3'd4: begin f20 = {w[31], w[19:12], w[20], w[30:21]}; v = longint'($signed(f20)) * 2; end
      3'd5: v = longint'(w[19:15]);
      3'd6: v = longint'(w[25:20]);
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected registered state, derived from the sampled inputs at each edge
  logic [63:0] m_imm_q;
  logic        m_valid_q;

  always @(posedge clk) begin
    if (rst) begin
      m_imm_q   <= '0;
      m_valid_q <= 1'b0;
    end else if (bus.valid_i) begin
      m_imm_q   <= ref_imm(bus.instr_i, bus.ExtOp);
      m_valid_q <= 1'b1;
    end else begin
      m_valid_q <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check64("model_imm", bus.imm, ref_imm(bus.instr_i, bus.ExtOp));
      check64("model_imm_q", bus.imm_q, m_imm_q);
      check1("model_valid_q", bus.valid_q, m_valid_q);
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] op);
    @(posedge clk);
    #1;
    bus.valid_i = v;
    bus.instr_i = w;
    bus.ExtOp   = op;
  endtask

  typedef struct {
    string       name;
    logic [31:0] w;
    logic [2:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"addi_m1",   32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"ebreak",    32'h00100073, 3'd0, 64'h0000_0000_0000_0001});
    vecs.push_back('{"lui_neg",   32'h800000B7, 3'd1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{"sw_m8",     32'hFE20AC23, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8});
    vecs.push_back('{"beq_m4",    32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC});
    vecs.push_back('{"beq_m2052", 32'hFE000E63, 3'd3, 64'hFFFF_FFFF_FFFF_F7FC});
    vecs.push_back('{"jal_2048",  32'h0010006F, 3'd4, 64'h0000_0000_0000_0800});
    vecs.push_back('{"jal_m2",    32'hFFFFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"zimm",      32'hFFFFFFFF, 3'd5, 64'h0000_0000_0000_001F});
    vecs.push_back('{"shamt",     32'hFFFFFFFF, 3'd6, 64'h0000_0000_0000_003F});
    vecs.push_back('{"none",      32'hFFFFFFFF, 3'd7, 64'h0000_0000_0000_0000});
    vecs.push_back('{"lui_pos",   32'h7FFFF0B7, 3'd1, 64'h0000_0000_7FFF_F000});

    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.instr_i = 32'hFFF00093;
    bus.ExtOp   = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset_imm_q", bus.imm_q, 64'h0);
    check1("reset_valid_q", bus.valid_q, 1'b0);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    chk_en      = 1'b1;

    // Directed formats, captured back-to-back
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].w, vecs[i].op);
      @(negedge clk);
      check64(vecs[i].name, bus.imm, vecs[i].exp);
    end

    // Registered path: pulse, idle hold, reset beating valid_i
    drive(1'b1, 32'hFFF00093, 3'd0);
    drive(1'b0, 32'h00100073, 3'd0);
    check64("pulse_imm_q", bus.imm_q, 64'hFFFF_FFFF_FFFF_FFFF);
    check1("pulse_valid_q", bus.valid_q, 1'b1);
    drive(1'b1, 32'h00100073, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check64("idle_then_rst_imm_q", bus.imm_q, 64'h0);
    check1("rst_with_valid_valid_q", bus.valid_q, 1'b0);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    check1("post_rst_idle_valid_q", bus.valid_q, 1'b0);
    drive(1'b1, 32'h0010006F, 3'd4);
    drive(1'b0, 32'h0, 3'd7);
    check64("first_after_rst_imm_q", bus.imm_q, 64'h800);
    check1("first_after_rst_valid_q", bus.valid_q, 1'b1);

    // Idle hold checked directly against the previously captured value
    drive(1'b0, 32'hFFFFFFFF, 3'd1);
    check64("hold_imm_q", bus.imm_q, 64'h800);
    check1("hold_valid_q", bus.valid_q, 1'b0);

    // Mixed traffic with occasional mid-stream resets
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      rst         = ($urandom_range(0, 24) == 0);
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.instr_i = $urandom;
      bus.ExtOp   = 3'($urandom_range(0, 7));
    end
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
